// File: rtl/bsg_loopback_test_node_pkg.sv
// Shared definitions for the loopback test node: counter width and the
// deterministic lane pattern generated and checked by the master node.
package bsg_loopback_test_node_pkg;

    localparam int CNT_WIDTH_LP = 32;
    localparam int MAX_WIDTH_LP = 256;

    // Lane k of packet n carries (n + k) mod 2^channel_width, lane 0 in the LSBs.
    function automatic logic [MAX_WIDTH_LP-1:0] packet(
        input logic [CNT_WIDTH_LP-1:0] n,
        input int                      num_channels,
        input int                      channel_width
    );
        logic [MAX_WIDTH_LP-1:0] w_pkt;
        logic [CNT_WIDTH_LP-1:0] w_mask;
        logic [CNT_WIDTH_LP-1:0] w_lane;
        w_pkt  = '0;
        w_mask = (channel_width >= 32'sd32) ? '1 : ((32'd1 << channel_width) - 32'd1);
        for (int k = 32'sd0; k < num_channels; k++) begin
            w_lane = (n + 32'(k)) & w_mask;
            w_pkt  = w_pkt | ({{(MAX_WIDTH_LP-CNT_WIDTH_LP){1'b0}}, w_lane} << (k * channel_width));
        end
        return w_pkt;
    endfunction

endpackage

// File: rtl/bsg_loopback_test_node_two_fifo.sv
// Two-entry ready/valid FIFO used as the echo buffer of a client node.
module bsg_two_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic               w_enq;
    logic               w_deq;

    assign ready_o = (r_count != 2'd2);
    assign v_o     = (r_count != 2'd0);
    assign data_o  = r_mem[r_rptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; occupancy decides what is visible
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_loopback_test_node.sv
// Loopback traffic generator/checker (master) or echo node (client).
// Define BSG_LOOPBACK_TEST_NODE_DISPLAY_EN for simulation-only mismatch reporting.
module bsg_loopback_test_node
    import bsg_loopback_test_node_pkg::*;
#(
    parameter int num_channels_p   = 2,
    parameter int channel_width_p  = 8,
    parameter int is_client_node_p = 0
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      en_i,
    input  logic                                      link_v_i,
    input  logic [num_channels_p*channel_width_p-1:0] link_data_i,
    output logic                                      link_ready_and_o,
    output logic                                      link_v_o,
    output logic [num_channels_p*channel_width_p-1:0] link_data_o,
    input  logic                                      link_ready_and_i,
    output logic                                      error_o,
    output logic [31:0]                               sent_o,
    output logic [31:0]                               received_o
);
    localparam int width_lp = num_channels_p * channel_width_p;

    logic [CNT_WIDTH_LP-1:0] r_sent;
    logic [CNT_WIDTH_LP-1:0] r_received;
    logic                    r_error;
    logic                    r_en;
    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic                    w_mismatch;
    logic [width_lp-1:0]     w_send_pkt;
    logic [width_lp-1:0]     w_recv_pkt;

    assign w_in_xfer  = link_v_i & link_ready_and_o;
    assign w_out_xfer = link_v_o & link_ready_and_i;
    assign w_send_pkt = width_lp'(packet(r_sent, num_channels_p, channel_width_p));
    assign w_recv_pkt = width_lp'(packet(r_received, num_channels_p, channel_width_p));

    // Counters advance only on completed transfers, so a withdrawn packet is resent with the same index
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sent     <= 32'd0;
            r_received <= 32'd0;
            r_error    <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            r_en <= en_i;
            if (w_out_xfer) r_sent <= r_sent + 32'd1;
            if (w_in_xfer) r_received <= r_received + 32'd1;
            if (w_mismatch) r_error <= 1'b1;
        end
    end

    assign sent_o     = r_sent;
    assign received_o = r_received;
    assign error_o    = r_error;

    generate
        if (is_client_node_p != 0) begin : g_client
            bsg_two_fifo #(.width_p(width_lp)) u_echo (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .ready_o (link_ready_and_o),
                .data_i  (link_data_i),
                .v_i     (link_v_i),
                .v_o     (link_v_o),
                .data_o  (link_data_o),
                .yumi_i  (w_out_xfer)
            );
            assign w_mismatch = 1'b0;
        end else begin : g_master
            // Always ready so in-flight packets drain after generation stops
            assign link_ready_and_o = 1'b1;
            assign link_v_o         = r_en;
            assign link_data_o      = w_send_pkt;
            assign w_mismatch       = w_in_xfer & (link_data_i != w_recv_pkt);

`ifdef BSG_LOOPBACK_TEST_NODE_DISPLAY_EN
            always @(posedge clk_i) begin
                if (!reset_i && w_mismatch) begin
                    $display("%t loopback node: packet %0d expected %h received %h",
                             $time, r_received, w_recv_pkt, link_data_i);
                    if (!r_error) $error("loopback node: first data error");
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_bsg_loopback_test_node.sv
// Scoreboard bench: a master node and a client node, routed by the bench
// as direct drive, master self-loop, or master -> client -> master.
`timescale 1ns/1ps
module tb_bsg_loopback_test_node;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         en;
    logic [1:0]   route;
    logic         tb_m_v, tb_m_rdy, tb_c_v, tb_c_rdy, rdy_a, rdy_b;
    logic [W-1:0] tb_m_data, tb_c_data;

    logic         m_v_i, m_ready_o, m_v_o, m_ready_i, m_err;
    logic [W-1:0] m_data_i, m_data_o;
    logic [31:0]  m_sent, m_rcv;
    logic         c_v_i, c_ready_o, c_v_o, c_ready_i, c_err;
    logic [W-1:0] c_data_i, c_data_o;
    logic [31:0]  c_sent, c_rcv;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_sent;
    logic [W-1:0] c_q[$];
    logic         hold_pend;
    logic [W-1:0] hold_data;

    bsg_loopback_test_node #(.num_channels_p(2), .channel_width_p(8), .is_client_node_p(0)) u_m (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .link_v_i(m_v_i), .link_data_i(m_data_i), .link_ready_and_o(m_ready_o),
        .link_v_o(m_v_o), .link_data_o(m_data_o), .link_ready_and_i(m_ready_i),
        .error_o(m_err), .sent_o(m_sent), .received_o(m_rcv));

    bsg_loopback_test_node #(.num_channels_p(2), .channel_width_p(8), .is_client_node_p(1)) u_c (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .link_v_i(c_v_i), .link_data_i(c_data_i), .link_ready_and_o(c_ready_o),
        .link_v_o(c_v_o), .link_data_o(c_data_o), .link_ready_and_i(c_ready_i),
        .error_o(c_err), .sent_o(c_sent), .received_o(c_rcv));

    // route 0: bench drives both nodes; 1: master self-loop; 2: master -> client -> master
    assign m_ready_i = (route == 2'd2) ? (c_ready_o & rdy_a) : tb_m_rdy;
    assign m_v_i     = (route == 2'd1) ? (m_v_o & tb_m_rdy) : (route == 2'd2) ? (c_v_o & rdy_b) : tb_m_v;
    assign m_data_i  = (route == 2'd1) ? m_data_o : (route == 2'd2) ? c_data_o : tb_m_data;
    assign c_v_i     = (route == 2'd2) ? (m_v_o & rdy_a) : tb_c_v;
    assign c_data_i  = (route == 2'd2) ? m_data_o : tb_c_data;
    assign c_ready_i = (route == 2'd2) ? rdy_b : tb_c_rdy;

    function automatic logic [W-1:0] pkt(input logic [31:0] n);
        logic [7:0] b;
        b = n[7:0];
        return {b + 8'd1, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        tb_m_rdy = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        step(); step();
        n = 0;
        while ((m_v_o || c_v_o || (m_sent != m_rcv)) && n < 200) begin
            step();
            n++;
        end
        chk(name, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: checks master output sequence, hold-during-stall, and client echo order
    always @(negedge clk) begin
        if (reset) begin
            exp_sent  = 32'd0;
            hold_pend = 1'b0;
            c_q.delete();
        end else begin
            if (hold_pend && m_v_o) chk("m_hold", 32'(m_data_o), 32'(hold_data));
            hold_pend = m_v_o && !m_ready_i;
            hold_data = m_data_o;
            if (m_v_o && m_ready_i) begin
                chk("m_data", 32'(m_data_o), 32'(pkt(exp_sent)));
                exp_sent = exp_sent + 32'd1;
            end
            if (c_v_o && c_ready_i) begin
                if (c_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL c_echo actual=%h required=<nothing queued>", c_data_o);
                end else begin
                    chk("c_echo", 32'(c_data_o), 32'(c_q.pop_front()));
                end
            end
            if (c_v_i && c_ready_o) c_q.push_back(c_data_i);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; route = 2'd0;
        tb_m_v = 1'b0; tb_m_rdy = 1'b0; tb_c_v = 1'b0; tb_c_rdy = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0; tb_m_data = 16'h0000; tb_c_data = 16'h0000;
        step(); step();
        chk("rst_sent", m_sent, 32'd0);
        chk("rst_rcv", m_rcv, 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_mv", 32'(m_v_o), 32'd0);
        chk("rst_cv", 32'(c_v_o), 32'd0);
        reset = 1'b0;
        chk("pkt0", 32'(m_data_o), 32'h0000_0100);

        // Self-loop, always ready, 100 cycles of enable
        route = 2'd1; tb_m_rdy = 1'b1; en = 1'b1;
        repeat (100) step();
        en = 1'b0;
        drain("t1_drain");
        chk("t1_sent", m_sent, 32'd100);
        chk("t1_rcv", m_rcv, 32'd100);
        chk("t1_model", m_sent, exp_sent);
        chk("t1_err", 32'(m_err), 32'd0);

        // Self-loop with random back-pressure
        en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tb_m_rdy = 1'($urandom_range(0, 1));
            step();
        end
        en = 1'b0;
        drain("t2_drain");
        chk("t2_sent", m_sent, exp_sent);
        chk("t2_rcv", m_rcv, exp_sent);
        chk("t2_err", 32'(m_err), 32'd0);

        // Asynchronous reset mid-run; sequence restarts at packet 0
        en = 1'b1;
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_sent", m_sent, 32'd0);
        chk("ar_rcv", m_rcv, 32'd0);
        chk("ar_v", 32'(m_v_o), 32'd0);
        chk("ar_err", 32'(m_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("ar_pkt0", 32'(m_data_o), 32'h0000_0100);
        repeat (10) step();
        en = 1'b0;
        drain("t3_drain");
        chk("t3_sent", m_sent, exp_sent);
        chk("t3_rcv", m_rcv, exp_sent);

        // Injected corruption: 0x0300 in place of packet 2
        do_reset();
        route = 2'd0; tb_m_rdy = 1'b1; tb_m_v = 1'b1;
        tb_m_data = 16'h0100; step();
        tb_m_data = 16'h0201; step();
        chk("inj_ok", 32'(m_err), 32'd0);
        tb_m_data = 16'h0300; step();
        chk("inj_err", 32'(m_err), 32'd1);
        tb_m_v = 1'b0;
        repeat (3) step();
        chk("inj_sticky", 32'(m_err), 32'd1);
        chk("inj_rcv", m_rcv, 32'd3);
        do_reset();
        chk("inj_clr", 32'(m_err), 32'd0);

        // Master through client echo with back-pressure on both sides
        route = 2'd2; en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            rdy_a = 1'($urandom_range(0, 1));
            rdy_b = 1'($urandom_range(0, 1));
            step();
        end
        en = 1'b0;
        drain("t5_drain");
        chk("t5_msent", m_sent, exp_sent);
        chk("t5_mrcv", m_rcv, exp_sent);
        chk("t5_csent", c_sent, exp_sent);
        chk("t5_crcv", c_rcv, exp_sent);
        chk("t5_merr", 32'(m_err), 32'd0);
        chk("t5_cerr", 32'(c_err), 32'd0);
        chk("t5_q", 32'(c_q.size()), 32'd0);

        // Client full and empty boundaries
        do_reset();
        route = 2'd0; tb_c_rdy = 1'b0; tb_c_v = 1'b1;
        tb_c_data = 16'hA5A5; step();
        tb_c_data = 16'h5A5A; step();
        chk("c_full_rdy", 32'(c_ready_o), 32'd0);
        chk("c_full_v", 32'(c_v_o), 32'd1);
        tb_c_data = 16'h1234; step();
        chk("c_stall_rcv", c_rcv, 32'd2);
        tb_c_v = 1'b0; tb_c_rdy = 1'b1;
        repeat (3) step();
        chk("c_sent", c_sent, 32'd2);
        chk("c_empty_v", 32'(c_v_o), 32'd0);
        chk("c_err", 32'(c_err), 32'd0);

        // Counter wrap from a preloaded value near 0xFFFF_FFFF
        do_reset();
        route = 2'd1; tb_m_rdy = 1'b1; en = 1'b0;
        step();
        force u_m.r_sent = 32'hFFFF_FFFD;
        force u_m.r_received = 32'hFFFF_FFFD;
        step();
        release u_m.r_sent;
        release u_m.r_received;
        exp_sent = 32'hFFFF_FFFD;
        chk("wr_pre", m_sent, 32'hFFFF_FFFD);
        en = 1'b1;
        repeat (8) step();
        en = 1'b0;
        drain("wr_drain");
        chk("wr_sent", m_sent, 32'd5);
        chk("wr_rcv", m_rcv, 32'd5);
        chk("wr_err", 32'(m_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
